nbiot_gold_seq_stream: RTL and testbench

Streaming length-31 Gold pseudo-random sequence generator, c(n) = (x1(n+NC) + x2(n+NC)) mod 2, per 36.211 §7.2. x1 uses a fixed seed; x2 is seeded from a runtime c_init. Replaces the one-shot full-vector generator: the sequence is produced OUT_W bits per beat over a valid/ready stream, from a run-time start and length. Feeds the NB-IoT uplink DMRS and scrambling blocks.

---
 rtl/nbiot_gold_seq_stream.sv | 183 ++++++++++++++++++
 tb/tb_nbiot_gold_seq_stream.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbiot_gold_seq_stream.sv
// ---------------------------------------------------------------------------
// nbiot_gold_seq_stream
//
// Streaming length-31 Gold sequence generator:
//     c(n) = x1(n+NC) ^ x2(n+NC)
// x1 starts from the fixed seed x1(0)=1, and x2 starts from a run-time c_init.
// After a warm-up of NC bits, the sequence is emitted OUT_W bits per beat on a
// valid/ready stream. Bit k of a beat carries c(beat*OUT_W + k), with the
// earliest bit in the LSB.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle request; only looked at while idle
//   c_init     x2 seed (bit k = x2(k)); captured together with start
//   seq_len    number of c(n) bits to emit; captured together with start
//   out_data   OUT_W sequence bits; bits past the end of the sequence are 0
//   out_valid  a beat is presented
//   out_ready  downstream accepts the beat
//   out_last   final beat of the sequence (qualified by out_valid)
//   busy       high whenever the generator is not idle
//   done       one-cycle pulse after the last beat is accepted
//              (or right after a zero-length request)
// ---------------------------------------------------------------------------
module nbiot_gold_seq_stream #(
    parameter int OUT_W = 8,
    parameter int NC    = 1600,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [30:0]      c_init,
    input  logic [LEN_W-1:0] seq_len,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int WARM_BEATS = NC / OUT_W;
    localparam int WARM_W     = (WARM_BEATS < 2) ? 1 : $clog2(WARM_BEATS + 1);
    localparam int REM_W      = LEN_W + 1;

    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARM_BEATS);
    localparam logic [REM_W-1:0]  OUT_W_REM = REM_W'(OUT_W);

    if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
        $error("nbiot_gold_seq_stream: OUT_W must be within 1..32");
    end
    if ((NC % OUT_W) != 0) begin : g_bad_nc
        $error("nbiot_gold_seq_stream: NC must be a multiple of OUT_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_STREAM
    } state_t;

    state_t            state_reg, state_next;
    logic [30:0]       x1_reg, x1_next;
    logic [30:0]       x2_reg, x2_next;
    logic [30:0]       c_init_reg, c_init_next;
    logic [REM_W-1:0]  rem_reg, rem_next;
    logic [WARM_W-1:0] warm_reg, warm_next;
    logic              done_reg, done_next;

    // Each register holds a 31-bit window of its sequence, with bit k = x(n+k).
    // One step shifts the window by one position and appends x(n+31). This
    // block unrolls OUT_W steps. The output bits are taken from bit 0 before
    // each step, so OUT_W = 32 also works even though the window is 31 bits.
    logic [30:0]      x1_adv, x2_adv;
    logic [OUT_W-1:0] c_bits;

    always_comb begin : p_advance
        logic [30:0] a;
        logic [30:0] b;
        a      = x1_reg;
        b      = x2_reg;
        c_bits = '0;
        for (int k = 0; k < OUT_W; k++) begin
            c_bits[k] = a[0] ^ b[0];
            a = {a[3] ^ a[0], a[30:1]};
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
        end
        x1_adv = a;
        x2_adv = b;
    end

    // Zero padding: keep bit k only while k < remaining. Every bit is kept
    // until the final beat.
    logic [OUT_W-1:0] pad_mask;
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pad
        assign pad_mask[gi] = (rem_reg > REM_W'(gi));
    end

    logic is_last;
    logic accept;

    assign out_valid = (state_reg == ST_STREAM);
    assign is_last   = (rem_reg <= OUT_W_REM);
    assign out_last  = out_valid & is_last;
    assign out_data  = out_valid ? (c_bits & pad_mask) : '0;
    assign accept    = out_valid & out_ready;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;

    always_comb begin
        state_next  = state_reg;
        x1_next     = x1_reg;
        x2_next     = x2_reg;
        c_init_next = c_init_reg;
        rem_next    = rem_reg;
        warm_next   = warm_reg;
        done_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        c_init_next = c_init;
                        rem_next    = {1'b0, seq_len};
                        state_next  = ST_LOAD;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                x1_next    = 31'd1;
                x2_next    = c_init_reg;
                warm_next  = WARM_INIT;
                state_next = (WARM_BEATS == 0) ? ST_STREAM : ST_WARM;
            end
            ST_WARM: begin
                x1_next   = x1_adv;
                x2_next   = x2_adv;
                warm_next = warm_reg - 1'b1;
                if (warm_reg == WARM_W'(1)) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    x1_next = x1_adv;
                    x2_next = x2_adv;
                    if (is_last) begin
                        rem_next   = '0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        rem_next = rem_reg - OUT_W_REM;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            x1_reg     <= '0;
            x2_reg     <= '0;
            c_init_reg <= '0;
            rem_reg    <= '0;
            warm_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x1_reg     <= x1_next;
            x2_reg     <= x2_next;
            c_init_reg <= c_init_next;
            rem_reg    <= rem_next;
            warm_reg   <= warm_next;
            done_reg   <= done_next;
        end
    end

endmodule

// File: tb/tb_nbiot_gold_seq_stream.sv
// ---------------------------------------------------------------------------
// tb_nbiot_gold_seq_stream
//
// Scoreboard bench for three generator configurations:
//   index 0: defaults   (OUT_W=8,  NC=1600)
//   index 1: OUT_W=32, NC=0
//   index 2: OUT_W=8,  NC=0
// Only one instance is active at any time, so all instances share a single
// expected-beat queue. Each queue entry records which instance must produce
// the beat. Expected beats come from a bit-serial Gold model, or from known
// constants.
// ---------------------------------------------------------------------------
module tb_nbiot_gold_seq_stream;

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  start_v;
    logic [30:0] c_init_tb;
    logic [15:0] seq_len_tb;
    logic        out_ready;
    int          ready_mode;   // 0: held low, 1: held high, 2: random

    logic [7:0]  data_a, data_c;
    logic [31:0] data_b;
    logic        valid_a, valid_b, valid_c;
    logic        last_a, last_b, last_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    logic [31:0] mon_data [3];
    logic        mon_valid [3];
    logic        mon_last [3];
    logic        mon_busy [3];
    logic        mon_done [3];

    exp_t        sb_q[$];
    int          checks;
    int          errors;

    logic [2:0]  done_pend;
    logic [2:0]  stall_prev;
    logic [31:0] stall_data [3];
    logic        stall_last [3];

    nbiot_gold_seq_stream #(.OUT_W(8), .NC(1600), .LEN_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .c_init(c_init_tb),
        .seq_len(seq_len_tb), .out_data(data_a), .out_valid(valid_a),
        .out_ready(out_ready), .out_last(last_a), .busy(busy_a), .done(done_a)
    );
    nbiot_gold_seq_stream #(.OUT_W(32), .NC(0), .LEN_W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .c_init(c_init_tb),
        .seq_len(seq_len_tb), .out_data(data_b), .out_valid(valid_b),
        .out_ready(out_ready), .out_last(last_b), .busy(busy_b), .done(done_b)
    );
    nbiot_gold_seq_stream #(.OUT_W(8), .NC(0), .LEN_W(16)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .c_init(c_init_tb),
        .seq_len(seq_len_tb), .out_data(data_c), .out_valid(valid_c),
        .out_ready(out_ready), .out_last(last_c), .busy(busy_c), .done(done_c)
    );

    assign mon_data[0]  = {24'b0, data_a};
    assign mon_data[1]  = data_b;
    assign mon_data[2]  = {24'b0, data_c};
    assign mon_valid[0] = valid_a;
    assign mon_valid[1] = valid_b;
    assign mon_valid[2] = valid_c;
    assign mon_last[0]  = last_a;
    assign mon_last[1]  = last_b;
    assign mon_last[2]  = last_c;
    assign mon_busy[0]  = busy_a;
    assign mon_busy[1]  = busy_b;
    assign mon_busy[2]  = busy_c;
    assign mon_done[0]  = done_a;
    assign mon_done[1]  = done_b;
    assign mon_done[2]  = done_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // out_ready changes 1 time unit after each rising edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Bit-serial Gold reference model. It builds x1 and x2 directly from
    // their recurrences, forms c(n), and packs c(n) into beats of w bits.
    function automatic void model_push(int dut, logic [30:0] ci, int len);
        int   w;
        int   nc;
        int   total;
        int   nb;
        bit   x1[];
        bit   x2[];
        exp_t e;
        w     = (dut == 1) ? 32 : 8;
        nc    = (dut == 0) ? 1600 : 0;
        total = nc + len + 31;
        x1    = new[total];
        x2    = new[total];
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0);
            x2[n] = ci[n];
        end
        for (int m = 31; m < total; m++) begin
            x1[m] = x1[m-28] ^ x1[m-31];
            x2[m] = x2[m-28] ^ x2[m-29] ^ x2[m-30] ^ x2[m-31];
        end
        nb = (len + w - 1) / w;
        for (int b = 0; b < nb; b++) begin
            e.dut  = 2'(dut);
            e.data = '0;
            e.last = (b == nb - 1);
            for (int k = 0; k < w; k++) begin
                if (b * w + k < len) e.data[k] = x1[b*w+k+nc] ^ x2[b*w+k+nc];
            end
            sb_q.push_back(e);
        end
    endfunction

    // Monitor: compares done against the expected pulse, checks that beats
    // stay stable while stalled, and pops and compares each accepted beat.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            done_pend  = '0;
            stall_prev = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mon_done[i] !== done_pend[i]) begin
                    errors++;
                    $display("FAIL done_pulse dut%0d got %b expected %b", i, mon_done[i], done_pend[i]);
                end
                done_pend[i] = 1'b0;
                if (stall_prev[i]) begin
                    checks++;
                    if (mon_valid[i] !== 1'b1 || mon_data[i] !== stall_data[i] || mon_last[i] !== stall_last[i]) begin
                        errors++;
                        $display("FAIL stall_hold dut%0d got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                 i, mon_valid[i], mon_data[i], mon_last[i], stall_data[i], stall_last[i]);
                    end
                end
                if (mon_valid[i]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid dut%0d got data=%h expected no beat", i, mon_data[i]);
                    end else if (out_ready) begin
                        e = sb_q.pop_front();
                        checks++;
                        if (e.dut !== 2'(i) || mon_data[i] !== e.data || mon_last[i] !== e.last) begin
                            errors++;
                            $display("FAIL beat dut%0d got data=%h last=%b expected dut%0d data=%h last=%b",
                                     i, mon_data[i], mon_last[i], e.dut, e.data, e.last);
                        end
                        done_pend[i] = e.last;
                    end
                end
                if (start_v[i] && !mon_busy[i] && seq_len_tb == 16'd0) done_pend[i] = 1'b1;
                stall_prev[i] = mon_valid[i] && !out_ready;
                stall_data[i] = mon_data[i];
                stall_last[i] = mon_last[i];
            end
        end
    end

    // These tasks are called at posedge+1.
    task automatic pulse_start(int dut, logic [30:0] ci, int len);
        c_init_tb  = ci;
        seq_len_tb = 16'(len);
        start_v[dut] = 1'b1;
        @(posedge clk);
        #1;
        start_v[dut] = 1'b0;
    endtask

    task automatic run_model(int dut, logic [30:0] ci, int len);
        if (len > 0) model_push(dut, ci, len);
        pulse_start(dut, ci, len);
    endtask

    task automatic wait_idle(int budget);
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || busy_a || busy_b || busy_c) && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL timeout got %0d beats still pending expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mon_valid[i] !== 1'b0 || mon_last[i] !== 1'b0 || mon_busy[i] !== 1'b0 ||
                mon_done[i] !== 1'b0 || mon_data[i] !== 32'd0) begin
                errors++;
                $display("FAIL %s dut%0d got v=%b l=%b b=%b d=%b data=%h expected all 0",
                         tag, i, mon_valid[i], mon_last[i], mon_busy[i], mon_done[i], mon_data[i]);
            end
        end
    endtask

    // Asserts reset between clock edges, checks that outputs clear at once,
    // then releases reset.
    task automatic async_reset(string tag);
        #1;
        reset = 1'b0;
        #1;
        check_zero(tag);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic full_run_a(bit with_latency_and_ignore);
        int cnt;
        ready_mode = 2;
        run_model(0, 31'd35, 20480);
        if (with_latency_and_ignore) begin
            cnt = 1;
            while (!valid_a && cnt < 400) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            checks++;
            if (cnt != 202) begin
                errors++;
                $display("FAIL latency got %0d cycles expected 202", cnt);
            end
            repeat (300) @(posedge clk);
            #1;
            pulse_start(0, 31'($urandom), 5);
        end
        wait_idle(30000);
    endtask

    initial begin
        int cnt;
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        start_v    = '0;
        c_init_tb  = '0;
        seq_len_tb = '0;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Known constant beats.
        sb_q.push_back('{dut: 2'd1, data: 32'h8000_0001, last: 1'b1});
        pulse_start(1, 31'd0, 32);
        wait_idle(100);
        sb_q.push_back('{dut: 2'd1, data: 32'h0000_0000, last: 1'b1});
        pulse_start(1, 31'd1, 32);
        wait_idle(100);
        sb_q.push_back('{dut: 2'd2, data: 32'h01, last: 1'b0});
        sb_q.push_back('{dut: 2'd2, data: 32'h00, last: 1'b1});
        pulse_start(2, 31'd0, 13);
        wait_idle(100);

        // Zero-length requests: done pulses, but no beats are emitted.
        for (int d = 0; d < 3; d++) begin
            pulse_start(d, 31'($urandom), 0);
            wait_idle(20);
        end

        // Random seeds and lengths with random backpressure, NC=0 instances.
        ready_mode = 2;
        for (int it = 0; it < 12; it++) begin
            run_model(1 + (it % 2), 31'($urandom), $urandom_range(1, 200));
            wait_idle(2000);
        end

        // Full default sequence: latency, random stalls, and a start pulse
        // mid-stream that must be ignored.
        full_run_a(1'b1);

        // Reset during warm-up.
        ready_mode = 1;
        run_model(0, 31'd35, 100);
        repeat (50) @(posedge clk);
        async_reset("reset_in_warm");

        // Reset during a stalled beat.
        run_model(0, 31'd35, 100);
        cnt = 0;
        while (!valid_a && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        async_reset("reset_in_stall");

        // After reset, the sequence must be reproduced from c(0).
        full_run_a(1'b0);

        // Short random runs on the default instance, including lengths that
        // are not multiples of 8.
        for (int it = 0; it < 3; it++) begin
            run_model(0, 31'($urandom), $urandom_range(1, 60));
            wait_idle(2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
